alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Clocked, parametrised successor of the single-cycle datapath ALU.
- Registers all results. Adds logical and arithmetic right shifts, signed set-less-than, and iterative unsigned multiply and divide into HI/LO registers.
- Uses a start/busy/done handshake so the multi-cycle datapath controller can stall on long operations.
- Sits in the EX stage between the register-file operand muxes and the EX/MEM result path.

Parameters:
WIDTH, 32, operand/result width in bits (≥4)
SHAMT_W, 5, shift-amount width; shifts use shift[SHAMT_W-1:0], must satisfy 2**SHAMT_W ≥ WIDTH
CNT_W, 6, iteration counter width; must hold WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  operation request, sampled on rising clk; ignored while busy=1
control  input  4  operation select
in1  input  WIDTH  operand A (rs)
in2  input  WIDTH  operand B (rt/imm)
shift  input  SHAMT_W  shift amount (shamt)
busy  output  1  high while a multiply/divide iterates
done  output  1  one-cycle pulse: out/zero (and hi/lo for mul/div) updated this cycle
out  output  WIDTH  registered result
zero  output  1  registered, =1 when out==0
hi  output  WIDTH  multiply high word / divide remainder
lo  output  WIDTH  multiply low word / divide quotient

Behaviour:
- Reset (rst_n=0, async): out=0, zero=1, hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Reset mid-operation aborts it; hi/lo are cleared.
- Operand capture: in1/in2/control/shift are captured on the start edge. Later input changes do not affect an operation in flight.
- Control encodings:
  - 0000 AND; 0001 OR; 0010 ADD (wraps mod 2^WIDTH, no overflow flag); 0110 SUB (wraps).
  - 0111 SLT, signed: out=1 if $signed(in1)<$signed(in2), else 0.
  - 1100 NOR; 1110 SLL in2<<shift; 1111 SRL in2>>shift, zero fill; 1101 SRA in2>>>shift, sign fill.
  - 1000 MULTU, multi-cycle; 1001 DIVU, multi-cycle.
  - 1010 MFHI: out=hi. 1011 MFLO: out=lo.
  - Any other code: out=0.
- Single-cycle ops (all except 1000/1001):
  - On the start edge in IDLE: out, zero and done=1 update together. Visible one cycle after start is asserted (latency 1).
  - busy stays 0. Back-to-back starts on consecutive cycles give consecutive done pulses.
- FSM states: IDLE, MUL, DIV.
- IDLE --start & MULTU--> MUL; IDLE --start & DIVU--> DIV. busy=1 and counter=0 from that edge.
- MUL: shift-add, one multiplier bit per cycle.
  - Completes after WIDTH iterations, then returns to IDLE.
  - On the completing edge: {hi,lo}=in1*in2 (2·WIDTH-bit unsigned), out=lo, zero=(lo==0), done=1, busy=0.
  - Total latency: WIDTH cycles from the start edge to done visible.
- DIV: restoring division, one quotient bit per cycle, WIDTH iterations.
  - On completion: lo=in1/in2, hi=in1%in2, out=lo, zero=(lo==0), done=1, busy=0.
  - Divide by zero (in2==0 at capture): no iteration. On the next edge lo=all ones, hi=in1, out=all ones, zero=0, done=1, return to IDLE (latency 2).
- While busy: out, zero, hi and lo hold their previous values; start is ignored (no queueing); done=0.
- done is 0 every cycle except completion cycles.
- Single-cycle ops never modify hi/lo.
- A start asserted on the same cycle busy falls (completing edge) is ignored. The controller must re-assert it the following cycle.

Test Plan:
- Reset mid-MULTU: start MULTU 7×9, drop rst_n at cycle 10 -> immediately out=0, zero=1, hi=lo=0, busy=0. After release, ADD 5+3 -> out=8, done pulse 1 cycle later.
- Single-cycle sweep, WIDTH=32:
  - SUB 3-3 -> out=0, zero=1.
  - SLT -1 vs 1 -> out=1.
  - SRA 0x80000000 by 4 -> 0xF8000000; SRL same -> 0x08000000.
  - SLL 1 by 31 -> 0x80000000.
  - NOR 0,0 -> 0xFFFFFFFF.
  - Code 0011 -> out=0, zero=1.
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> busy=1 for 32 cycles; done at cycle 32 with hi=0xFFFFFFFE, lo=0x00000001. Then MFHI -> out=0xFFFFFFFE.
- DIVU 100/7 -> done after 32 cycles, lo=14, hi=2. Extra start and operand changes pulsed at cycle 5 are ignored (result unchanged, single done).
- DIVU 55/0 -> done at latency 2, lo=0xFFFFFFFF, hi=55, zero=0, no busy period beyond one cycle.
- Parameter WIDTH=8, SHAMT_W=3, CNT_W=4: MULTU 0xFF×0x02 -> done after 8 cycles, hi=0x01, lo=0xFE. ADD 0xFF+0x01 -> out=0x00, zero=1.

Source files
------------

// File: rtl/alu_seq_if.sv
// ------------------------------------------------------------------
// alu_seq_if : start/busy/done operand and result bundle for alu_seq
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface alu_seq_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
);
   logic               start;
   logic [3:0]         control;
   logic [WIDTH-1:0]   in1;
   logic [WIDTH-1:0]   in2;
   logic [SHAMT_W-1:0] shift;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   out;
   logic               zero;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;

   modport master (
      output start, control, in1, in2, shift,
      input  busy, done, out, zero, hi, lo
   );

   modport slave (
      input  start, control, in1, in2, shift,
      output busy, done, out, zero, hi, lo
   );
endinterface

`default_nettype wire

// File: rtl/alu_seq.sv
// ------------------------------------------------------------------
// alu_seq : registered EX-stage ALU with iterative MULTU/DIVU into HI/LO
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module alu_seq #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int CNT_W   = 6
) (
   input  wire logic clk,
   input  wire logic rst_n,
   alu_seq_if.slave  bus
);

   localparam logic [3:0] c_and  = 4'b0000;
   localparam logic [3:0] c_or   = 4'b0001;
   localparam logic [3:0] c_add  = 4'b0010;
   localparam logic [3:0] c_sub  = 4'b0110;
   localparam logic [3:0] c_slt  = 4'b0111;
   localparam logic [3:0] c_mul  = 4'b1000;
   localparam logic [3:0] c_div  = 4'b1001;
   localparam logic [3:0] c_mfhi = 4'b1010;
   localparam logic [3:0] c_mflo = 4'b1011;
   localparam logic [3:0] c_nor  = 4'b1100;
   localparam logic [3:0] c_sra  = 4'b1101;
   localparam logic [3:0] c_sll  = 4'b1110;
   localparam logic [3:0] c_srl  = 4'b1111;

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_mul  = 2'd1;
   localparam logic [1:0] c_st_div  = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_opb;
   logic [WIDTH-1:0] r_wh;
   logic [WIDTH-1:0] r_wl;
   logic [WIDTH-1:0] r_out;
   logic             r_zero;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_done;
   logic             w_busy;
   logic             w_last;
   logic             w_div0;
   logic [WIDTH-1:0] w_alu;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH-1:0] w_mul_hi;
   logic [WIDTH-1:0] w_mul_lo;
   logic [WIDTH:0]   w_div_sh;
   logic             w_div_ge;
   logic [WIDTH-1:0] w_div_hi;
   logic [WIDTH-1:0] w_div_lo;

   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_div0 = (r_opb == '0);

   // Single-cycle result straight from the operands presented on the start edge
   always_comb begin
      w_alu = '0;
      case (bus.control)
         c_and:   w_alu = bus.in1 & bus.in2;
         c_or:    w_alu = bus.in1 | bus.in2;
         c_add:   w_alu = bus.in1 + bus.in2;
         c_sub:   w_alu = bus.in1 - bus.in2;
         c_slt:   w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.in1) < $signed(bus.in2))};
         c_nor:   w_alu = ~(bus.in1 | bus.in2);
         c_sll:   w_alu = bus.in2 << bus.shift;
         c_srl:   w_alu = bus.in2 >> bus.shift;
         c_sra:   w_alu = $signed(bus.in2) >>> bus.shift;
         c_mfhi:  w_alu = r_hi;
         c_mflo:  w_alu = r_lo;
         default: w_alu = '0;
      endcase
   end

   // Shift-add step: {carry,hi,lo} shifted right, multiplier bits leave through lo[0]
   always_comb begin
      w_mul_sum = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
      w_mul_hi  = w_mul_sum[WIDTH:1];
      w_mul_lo  = {w_mul_sum[0], r_wl[WIDTH-1:1]};
   end

   // Restoring step: remainder in wh, dividend shifts out of wl while quotient shifts in
   always_comb begin
      w_div_sh = {r_wh, r_wl[WIDTH-1]};
      w_div_ge = (w_div_sh >= {1'b0, r_opb});
      w_div_hi = w_div_ge ? (w_div_sh[WIDTH-1:0] - r_opb) : w_div_sh[WIDTH-1:0];
      w_div_lo = {r_wl[WIDTH-2:0], w_div_ge};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= c_st_idle;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_idle: begin
            if (bus.start && bus.control == c_mul)      w_next_state = c_st_mul;
            else if (bus.start && bus.control == c_div) w_next_state = c_st_div;
         end
         c_st_mul: if (w_last)           w_next_state = c_st_idle;
         c_st_div: if (w_div0 || w_last) w_next_state = c_st_idle;
         default:  w_next_state = c_st_idle;
      endcase
   end

   always_comb begin
      w_busy = (r_state != c_st_idle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_opb  <= '0;
         r_wh   <= '0;
         r_wl   <= '0;
         r_out  <= '0;
         r_zero <= 1'b1;
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            c_st_idle: begin
               if (bus.start) begin
                  case (bus.control)
                     c_mul: begin
                        r_cnt <= '0;
                        r_wh  <= '0;
                        r_wl  <= bus.in2;
                        r_opb <= bus.in1;
                     end
                     c_div: begin
                        r_cnt <= '0;
                        r_wh  <= '0;
                        r_wl  <= bus.in1;
                        r_opb <= bus.in2;
                     end
                     default: begin
                        r_out  <= w_alu;
                        r_zero <= (w_alu == '0);
                        r_done <= 1'b1;
                     end
                  endcase
               end
            end
            c_st_mul: begin
               r_cnt <= r_cnt + CNT_W'(1);
               r_wh  <= w_mul_hi;
               r_wl  <= w_mul_lo;
               if (w_last) begin
                  r_hi   <= w_mul_hi;
                  r_lo   <= w_mul_lo;
                  r_out  <= w_mul_lo;
                  r_zero <= (w_mul_lo == '0);
                  r_done <= 1'b1;
               end
            end
            c_st_div: begin
               if (w_div0) begin
                  // Dividend is still parked in wl; it becomes the remainder
                  r_hi   <= r_wl;
                  r_lo   <= '1;
                  r_out  <= '1;
                  r_zero <= 1'b0;
                  r_done <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  r_wh  <= w_div_hi;
                  r_wl  <= w_div_lo;
                  if (w_last) begin
                     r_hi   <= w_div_hi;
                     r_lo   <= w_div_lo;
                     r_out  <= w_div_lo;
                     r_zero <= (w_div_lo == '0);
                     r_done <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = w_busy;
   assign bus.done = r_done;
   assign bus.out  = r_out;
   assign bus.zero = r_zero;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ------------------------------------------------------------------
// tb_alu_seq : scoreboard bench for alu_seq at WIDTH=32 and WIDTH=8
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_alu_seq;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(32), .SHAMT_W(5)) if32 ();
   alu_seq_if #(.WIDTH(8),  .SHAMT_W(3)) if8 ();

   alu_seq #(.WIDTH(32), .SHAMT_W(5), .CNT_W(6)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
   alu_seq #(.WIDTH(8),  .SHAMT_W(3), .CNT_W(4)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));

   typedef struct {
      logic [31:0] out;
      logic        zero;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
      int          nbusy;
   } exp_t;

   exp_t        sb0[$];
   exp_t        sb1[$];
   logic [31:0] m_hi[2];
   logic [31:0] m_lo[2];
   int          n_vec = 0;
   int          n_err = 0;

   logic [31:0] ob_out[2], ob_hi[2], ob_lo[2];
   logic        ob_zero[2], ob_done[2], ob_busy[2];

   always_comb begin
      ob_out[0] = if32.out;  ob_hi[0] = if32.hi;  ob_lo[0] = if32.lo;
      ob_zero[0] = if32.zero; ob_done[0] = if32.done; ob_busy[0] = if32.busy;
      ob_out[1] = {24'h0, if8.out}; ob_hi[1] = {24'h0, if8.hi}; ob_lo[1] = {24'h0, if8.lo};
      ob_zero[1] = if8.zero; ob_done[1] = if8.done; ob_busy[1] = if8.busy;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int d, input logic st, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b, input int sh);
      if (d == 0) begin
         if32.start = st; if32.control = c; if32.in1 = a; if32.in2 = b; if32.shift = 5'(sh);
      end else begin
         if8.start = st; if8.control = c; if8.in1 = a[7:0]; if8.in2 = b[7:0]; if8.shift = 3'(sh);
      end
   endtask

   // Behavioural reference: whole-word arithmetic, no iteration
   task automatic push_exp(input int d, input logic [3:0] c,
                           input logic [31:0] a_in, input logic [31:0] b_in, input int sh);
      int          w;
      logic [63:0] mask, a, b, sa, sbx, r, p;
      exp_t        e;
      w    = (d == 0) ? 32 : 8;
      mask = (64'd1 << w) - 64'd1;
      a    = {32'h0, a_in} & mask;
      b    = {32'h0, b_in} & mask;
      sa   = a[w-1] ? (a | ~mask) : a;
      sbx  = b[w-1] ? (b | ~mask) : b;
      e.lat = 1; e.nbusy = 0;
      r = 64'h0;
      case (c)
         4'h0: r = a & b;
         4'h1: r = a | b;
         4'h2: r = (a + b) & mask;
         4'h6: r = (a - b) & mask;
         4'h7: r = ($signed(sa) < $signed(sbx)) ? 64'd1 : 64'd0;
         4'hC: r = ~(a | b) & mask;
         4'hE: r = (b << sh) & mask;
         4'hF: r = b >> sh;
         4'hD: r = ($signed(sbx) >>> sh) & mask;
         4'hA: r = {32'h0, m_hi[d]};
         4'hB: r = {32'h0, m_lo[d]};
         4'h8: begin
            p = a * b;
            m_hi[d] = 32'((p >> w) & mask);
            m_lo[d] = 32'(p & mask);
            r = {32'h0, m_lo[d]};
            e.lat = w + 1; e.nbusy = w;
         end
         4'h9: begin
            if (b == 64'h0) begin
               m_lo[d] = 32'(mask); m_hi[d] = 32'(a);
               e.lat = 2; e.nbusy = 1;
            end else begin
               m_lo[d] = 32'(a / b); m_hi[d] = 32'(a % b);
               e.lat = w + 1; e.nbusy = w;
            end
            r = {32'h0, m_lo[d]};
         end
         default: r = 64'h0;
      endcase
      e.out  = r[31:0];
      e.zero = (r == 64'h0);
      e.hi   = m_hi[d];
      e.lo   = m_lo[d];
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
   endtask

   task automatic pop_exp(input int d, output exp_t e, output bit ok);
      ok = 1'b0;
      e.out = '0; e.zero = 1'b0; e.hi = '0; e.lo = '0; e.lat = -2; e.nbusy = -2;
      if (d == 0 && sb0.size() > 0) begin e = sb0.pop_front(); ok = 1'b1; end
      else if (d == 1 && sb1.size() > 0) begin e = sb1.pop_front(); ok = 1'b1; end
   endtask

   // One-cycle start pulse then a bounded wait for done; lat=-1 on timeout
   task automatic run_op(input int d, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input int sh, output int lat, output int nbusy);
      push_exp(d, c, a, b, sh);
      drive(d, 1'b1, c, a, b, sh);
      tick;
      drive(d, 1'b0, c, a, b, sh);
      lat = 1; nbusy = 0;
      while (!ob_done[d] && lat <= 200) begin
         if (ob_busy[d]) nbusy++;
         tick;
         lat++;
      end
      if (!ob_done[d]) lat = -1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      drive(0, 1'b0, 4'h0, 0, 0, 0);
      drive(1, 1'b0, 4'h0, 0, 0, 0);
      m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
      tick; tick;
      for (int d = 0; d < 2; d++) begin
         n_vec++;
         if ({ob_out[d], ob_zero[d], ob_hi[d], ob_lo[d], ob_busy[d], ob_done[d]} !==
             {32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset[%0d]: out=%h zero=%b hi=%h lo=%h busy=%b done=%b, want 0/1/0/0/0/0",
                     d, ob_out[d], ob_zero[d], ob_hi[d], ob_lo[d], ob_busy[d], ob_done[d]);
         end
      end
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_single_cycle;
      logic [3:0]  cs[10] = '{4'h6, 4'h7, 4'hD, 4'hF, 4'hE, 4'hC, 4'h3, 4'h2, 4'h0, 4'h7};
      logic [31:0] as[10] = '{32'd3, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'd5,
                              32'hFFFFFFFF, 32'hF0F0F0F0, 32'd1};
      logic [31:0] bs[10] = '{32'd3, 32'd1, 32'h80000000, 32'h80000000, 32'd1, 32'h0, 32'd6,
                              32'd2, 32'h3C3C3C3C, 32'hFFFFFFFF};
      int          ss[10] = '{0, 0, 4, 4, 31, 0, 0, 0, 0, 0};
      int lat, nb; exp_t e; bit ok;
      for (int i = 0; i < 10; i++) begin
         run_op(0, cs[i], as[i], bs[i], ss[i], lat, nb);
         pop_exp(0, e, ok);
         n_vec++;
         if (!ok || lat !== e.lat || nb !== e.nbusy ||
             {ob_out[0], ob_zero[0], ob_hi[0], ob_lo[0]} !== {e.out, e.zero, e.hi, e.lo}) begin
            n_err++;
            $display("FAIL single[%0d] ctl=%h: out=%h zero=%b hi=%h lo=%h lat=%0d busy=%0d, want %h/%b/%h/%h lat=%0d busy=%0d",
                     i, cs[i], ob_out[0], ob_zero[0], ob_hi[0], ob_lo[0], lat, nb,
                     e.out, e.zero, e.hi, e.lo, e.lat, e.nbusy);
         end
      end
   endtask

   task automatic test_multu;
      logic [3:0]  cs[3] = '{4'h8, 4'hA, 4'hB};
      int lat, nb; exp_t e; bit ok;
      for (int i = 0; i < 3; i++) begin
         run_op(0, cs[i], 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat, nb);
         pop_exp(0, e, ok);
         n_vec++;
         if (!ok || lat !== e.lat || nb !== e.nbusy || ob_busy[0] !== 1'b0 ||
             {ob_out[0], ob_zero[0], ob_hi[0], ob_lo[0]} !== {e.out, e.zero, e.hi, e.lo}) begin
            n_err++;
            $display("FAIL multu[%0d]: out=%h zero=%b hi=%h lo=%h lat=%0d busy=%0d, want %h/%b/%h/%h lat=%0d busy=%0d",
                     i, ob_out[0], ob_zero[0], ob_hi[0], ob_lo[0], lat, nb,
                     e.out, e.zero, e.hi, e.lo, e.lat, e.nbusy);
         end
      end
   endtask

   task automatic test_divu_ignore;
      int ndone, first; exp_t e; bit ok;
      push_exp(0, 4'h9, 32'd100, 32'd7, 0);
      drive(0, 1'b1, 4'h9, 32'd100, 32'd7, 0);
      tick;
      drive(0, 1'b0, 4'h9, 32'd100, 32'd7, 0);
      ndone = 0; first = -1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (ob_done[0]) begin
            ndone++;
            if (first < 0) begin
               first = cyc;
               pop_exp(0, e, ok);
               n_vec++;
               if (!ok || {ob_out[0], ob_zero[0], ob_hi[0], ob_lo[0]} !== {e.out, e.zero, e.hi, e.lo}) begin
                  n_err++;
                  $display("FAIL divu result: out=%h zero=%b hi=%h lo=%h, want %h/%b/%h/%h",
                           ob_out[0], ob_zero[0], ob_hi[0], ob_lo[0], e.out, e.zero, e.hi, e.lo);
               end
            end
         end
         if (cyc == 5)      drive(0, 1'b1, 4'h8, 32'd12345, 32'd678, 3);
         else if (cyc == 6) drive(0, 1'b0, 4'h2, 32'd999, 32'd1, 0);
         tick;
      end
      n_vec++;
      if (ndone !== 1 || first !== 33) begin
         n_err++;
         $display("FAIL divu done count: dones=%0d first=%0d, want 1 at 33", ndone, first);
      end
      sb0.delete();
   endtask

   task automatic test_div0;
      int lat, nb; exp_t e; bit ok;
      run_op(0, 4'h9, 32'd55, 32'd0, 0, lat, nb);
      pop_exp(0, e, ok);
      n_vec++;
      if (!ok || lat !== e.lat || nb !== e.nbusy ||
          {ob_out[0], ob_zero[0], ob_hi[0], ob_lo[0]} !== {e.out, e.zero, e.hi, e.lo}) begin
         n_err++;
         $display("FAIL div0: out=%h zero=%b hi=%h lo=%h lat=%0d busy=%0d, want %h/%b/%h/%h lat=%0d busy=%0d",
                  ob_out[0], ob_zero[0], ob_hi[0], ob_lo[0], lat, nb,
                  e.out, e.zero, e.hi, e.lo, e.lat, e.nbusy);
      end
   endtask

   task automatic test_back_to_back;
      logic [3:0]  cs[4] = '{4'h2, 4'h6, 4'h1, 4'hB};
      logic [31:0] as[4] = '{32'd10, 32'd4, 32'h00FF0000, 32'd0};
      logic [31:0] bs[4] = '{32'd20, 32'd9, 32'h0000FF00, 32'd0};
      exp_t e; bit ok;
      for (int i = 0; i < 4; i++) begin
         push_exp(0, cs[i], as[i], bs[i], 0);
         drive(0, 1'b1, cs[i], as[i], bs[i], 0);
         tick;
         pop_exp(0, e, ok);
         n_vec++;
         if (!ok || ob_done[0] !== 1'b1 ||
             {ob_out[0], ob_zero[0], ob_hi[0], ob_lo[0]} !== {e.out, e.zero, e.hi, e.lo}) begin
            n_err++;
            $display("FAIL b2b[%0d]: done=%b out=%h zero=%b hi=%h lo=%h, want 1/%h/%b/%h/%h",
                     i, ob_done[0], ob_out[0], ob_zero[0], ob_hi[0], ob_lo[0], e.out, e.zero, e.hi, e.lo);
         end
      end
      drive(0, 1'b0, 4'h0, 0, 0, 0);
      tick;
      n_vec++;
      if (ob_done[0] !== 1'b0) begin
         n_err++;
         $display("FAIL b2b idle done: got %b, want 0", ob_done[0]);
      end
   endtask

   task automatic test_reset_mid_op;
      int lat, nb; exp_t e; bit ok;
      drive(0, 1'b1, 4'h8, 32'd7, 32'd9, 0);
      tick;
      drive(0, 1'b0, 4'h8, 32'd7, 32'd9, 0);
      for (int k = 1; k < 10; k++) tick;
      n_vec++;
      if (ob_busy[0] !== 1'b1) begin
         n_err++;
         $display("FAIL midop busy: got %b, want 1", ob_busy[0]);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({ob_out[0], ob_zero[0], ob_hi[0], ob_lo[0], ob_busy[0], ob_done[0]} !==
          {32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL midop reset: out=%h zero=%b hi=%h lo=%h busy=%b done=%b, want 0/1/0/0/0/0",
                  ob_out[0], ob_zero[0], ob_hi[0], ob_lo[0], ob_busy[0], ob_done[0]);
      end
      m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
      sb0.delete(); sb1.delete();
      tick;
      rst_n = 1'b1;
      tick;
      run_op(0, 4'h2, 32'd5, 32'd3, 0, lat, nb);
      pop_exp(0, e, ok);
      n_vec++;
      if (!ok || lat !== 1 || ob_out[0] !== 32'd8 || ob_out[0] !== e.out || ob_zero[0] !== 1'b0) begin
         n_err++;
         $display("FAIL post-reset add: out=%h zero=%b lat=%0d, want 00000008/0 lat=1",
                  ob_out[0], ob_zero[0], lat);
      end
   endtask

   task automatic test_width8;
      logic [3:0]  cs[5] = '{4'h8, 4'h2, 4'h9, 4'hD, 4'hA};
      logic [31:0] as[5] = '{32'hFF, 32'hFF, 32'hC8, 32'h0, 32'h0};
      logic [31:0] bs[5] = '{32'h02, 32'h01, 32'h0D, 32'h80, 32'h0};
      int          ss[5] = '{0, 0, 0, 3, 0};
      int lat, nb; exp_t e; bit ok;
      for (int i = 0; i < 5; i++) begin
         run_op(1, cs[i], as[i], bs[i], ss[i], lat, nb);
         pop_exp(1, e, ok);
         n_vec++;
         if (!ok || lat !== e.lat || nb !== e.nbusy ||
             {ob_out[1], ob_zero[1], ob_hi[1], ob_lo[1]} !== {e.out, e.zero, e.hi, e.lo}) begin
            n_err++;
            $display("FAIL w8[%0d] ctl=%h: out=%h zero=%b hi=%h lo=%h lat=%0d busy=%0d, want %h/%b/%h/%h lat=%0d busy=%0d",
                     i, cs[i], ob_out[1], ob_zero[1], ob_hi[1], ob_lo[1], lat, nb,
                     e.out, e.zero, e.hi, e.lo, e.lat, e.nbusy);
         end
      end
   endtask

   initial begin
      test_reset;
      test_single_cycle;
      test_multu;
      test_divu_ignore;
      test_div0;
      test_back_to_back;
      test_reset_mid_op;
      test_width8;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
